// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned FRAME_LEN = 10;

endpackage

// File: rtl/spi_tx_serializer.sv
// Load-and-shift MISO driver: MSB on the load edge, remaining bits on the
// following edges, then 0 until the next load.
module spi_tx_serializer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clr,
    input  logic [Width-1:0] i_data,
    output logic             o_miso,
    output logic             o_busy
);
    localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

    logic [Width-1:0] r_shift;
    logic [CntW-1:0]  r_cnt;
    logic             r_miso;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (i_clr) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
        end else if (i_load && !r_busy) begin
            r_shift <= {i_data[Width-2:0], 1'b0};
            r_miso  <= i_data[Width-1];
            r_cnt   <= CntW'(Width - 1);
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_miso <= 1'b0;
                r_busy <= 1'b0;
            end else begin
                r_miso  <= r_shift[Width-1];
                r_shift <= {r_shift[Width-2:0], 1'b0};
                r_cnt   <= r_cnt - CntW'(1);
            end
        end
    end

    assign o_miso = r_miso;
    assign o_busy = r_busy;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises MOSI frames for the RAM and serialises
// RAM read data back on MISO.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    localparam int unsigned FrameW = ADDR_SIZE + 2;
    localparam int unsigned CntW   = $clog2(FrameW + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
    localparam logic [CntW-1:0] CntDone = CntW'(FrameW);

    state_e            r_state;
    logic [FrameW-2:0] r_shift;
    logic [CntW-1:0]   r_cnt;
    logic              r_rd_addr_seen;
    logic              r_wait_tx;
    logic [FrameW-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              w_tx_load;
    logic              w_tx_busy;
    logic              w_miso;

    // Only the first tx_valid after a READ_DATA frame starts a shift-out.
    assign w_tx_load = (r_state == READ_DATA) && r_wait_tx && tx_valid && !SS_n && !w_tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_rd_addr_seen <= 1'b0;
            r_wait_tx      <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_tx_load) begin
                r_wait_tx <= 1'b0;
            end
            if (SS_n) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_wait_tx <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: r_state <= CHK_CMD;
                    CHK_CMD: begin
                        r_shift <= {r_shift[FrameW-3:0], MOSI};
                        r_cnt   <= CntW'(1);
                        if (!MOSI) begin
                            r_state <= WRITE;
                        end else if (r_rd_addr_seen) begin
                            r_state <= READ_DATA;
                        end else begin
                            r_state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        // Counter parks at CntDone so trailing bits are dropped.
                        if (r_cnt < CntDone) begin
                            r_shift <= {r_shift[FrameW-3:0], MOSI};
                            r_cnt   <= r_cnt + CntW'(1);
                            if (r_cnt == CntLast) begin
                                r_rx_data  <= {r_shift, MOSI};
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD) begin
                                    r_rd_addr_seen <= 1'b1;
                                end
                                if (r_state == READ_DATA) begin
                                    r_rd_addr_seen <= 1'b0;
                                    r_wait_tx      <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    spi_tx_serializer #(
        .Width (ADDR_SIZE)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_tx_load),
        .i_clr  (SS_n),
        .i_data (tx_data),
        .o_miso (w_miso),
        .o_busy (w_tx_busy)
    );

    assign MISO     = w_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed, table-driven bench for spi_slave.
module tb_spi_slave;
    import spi_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int total;
    int bad;

    spi_slave #(
        .ADDR_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        int         extra;
        state_e     st;
        logic       seen;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SS_n low, then the 10 frame bits; vm[e] holds rx_valid after edge k+e.
    task automatic send_frame(input logic [9:0] f, output logic [10:0] vm);
        vm   = '0;
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        vm[0] = rx_valid;
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
            tick();
            vm[10-i] = rx_valid;
        end
    endtask

    task automatic run_frame(input logic [9:0] f, input int extra, input state_e st,
                             input logic seen);
        logic [10:0] vm;
        logic        late;
        send_frame(f, vm);
        check("rx_data", 32'(rx_data), 32'(f));
        check("state_at_end", 32'(dut.r_state), 32'(st));
        late = 1'b0;
        for (int j = 0; j < extra; j++) begin
            MOSI = 1'b1;
            tick();
            late = late | rx_valid;
        end
        check("rd_addr_seen", 32'(dut.r_rd_addr_seen), 32'(seen));
        SS_n = 1'b1;
        MOSI = 1'b0;
        tick();
        late = late | rx_valid;
        check("rx_valid_pulse", {20'h0, late, vm}, 32'h400);
        check("idle_after_ss", 32'(dut.r_state), 32'(IDLE));
        check("miso_idle", 32'(MISO), 32'h0);
    endtask

    initial begin
        logic [10:0] vm;
        logic        seen_v;
        logic [7:0]  rd_exp;

        total    = 0;
        bad      = 0;
        vecs[0]  = '{10'h0E6, 0, WRITE, 1'b0};
        vecs[1]  = '{10'h1E6, 2, WRITE, 1'b0};
        vecs[2]  = '{10'h2E6, 0, READ_ADD, 1'b1};
        vecs[3]  = '{10'h1A5, 0, WRITE, 1'b1};
        vecs[4]  = '{10'h3C3, 0, READ_DATA, 1'b0};

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        #12;
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        check("rst_seen", 32'(dut.r_rd_addr_seen), 32'h0);
        rst_n = 1'b1;
        seen_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_v = seen_v | rx_valid | MISO;
        end
        check("idle_quiet", 32'(seen_v), 32'h0);
        tx_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].frame, vecs[i].extra, vecs[i].st, vecs[i].seen);
        end

        // Abort after 6 bits, then a clean frame.
        SS_n   = 1'b0;
        seen_v = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            MOSI = 1'b1;
            tick();
            seen_v = seen_v | rx_valid;
        end
        SS_n = 1'b1;
        tick();
        seen_v = seen_v | rx_valid;
        check("abort_no_valid", 32'(seen_v), 32'h0);
        check("abort_idle", 32'(dut.r_state), 32'(IDLE));
        check("abort_cnt", 32'(dut.r_cnt), 32'h0);
        run_frame(10'h0A5, 0, WRITE, 1'b0);

        // Read address then read data with a shifted-out response.
        run_frame(10'h2E6, 0, READ_ADD, 1'b1);
        send_frame(10'h3E6, vm);
        check("rd_valid", 32'(vm), 32'h400);
        check("rd_state", 32'(dut.r_state), 32'(READ_DATA));
        check("rd_miso_pre", 32'(MISO), 32'h0);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        rd_exp   = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            tick();
            tx_data = 8'h3C;
            check("rd_miso_bit", 32'(MISO), 32'(rd_exp[i]));
            if (i == 5) tx_valid = 1'b0;
        end
        tick();
        check("rd_miso_tail0", 32'(MISO), 32'h0);
        tick();
        check("rd_miso_tail1", 32'(MISO), 32'h0);
        check("rd_seen_clr", 32'(dut.r_rd_addr_seen), 32'h0);
        SS_n = 1'b1;
        tick();

        // Asynchronous reset during shift-out.
        run_frame(10'h2E6, 0, READ_ADD, 1'b1);
        send_frame(10'h3E6, vm);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("pre_rst_miso", 32'(MISO), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_miso", 32'(MISO), 32'h0);
        check("async_state", 32'(dut.r_state), 32'(IDLE));
        check("async_seen", 32'(dut.r_rd_addr_seen), 32'h0);
        check("async_rx_data", 32'(rx_data), 32'h0);
        #2;
        rst_n = 1'b1;
        SS_n  = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave front end that feeds the single-port RAM. It deserialises MOSI into 10-bit command/data words and presents each one to the RAM with a one-cycle `rx_valid` pulse. It also serialises the RAM's read data back out on MISO. It sits directly upstream of the RAM: `rx_data`/`rx_valid` drive the RAM `din`/`rx_valid`, and the RAM `dout`/`tx_valid` drive `tx_data`/`tx_valid` here.

## Interface
Parameters:
- `ADDR_SIZE`, default 8: RAM address/data width; frame width is `ADDR_SIZE+2`.

Ports:
- `clk`: input, 1 bit. Single clock, also the SPI bit clock. MOSI is sampled and MISO is driven on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `SS_n`: input, 1 bit. Slave select, active low; frames a transaction.
- `MOSI`: input, 1 bit. Serial data in, MSB first.
- `MISO`: output, 1 bit. Serial data out, MSB first.
- `rx_data`: output, `ADDR_SIZE+2` bits. Captured frame; bits [9:8] are the command, bits [7:0] are the payload.
- `rx_valid`: output, 1 bit. One-cycle strobe: `rx_data` is valid.
- `tx_data`: input, `ADDR_SIZE` bits. Read data from the RAM.
- `tx_valid`: input, 1 bit. `tx_data` is valid this cycle.

## Operation
- Reset values: state IDLE; `MISO`=0; `rx_valid`=0; `rx_data`=0; bit counter 0; `rd_addr_seen` flag 0.
- States:
  - IDLE: leave when `SS_n`=0; go to CHK_CMD.
  - CHK_CMD: the MOSI bit sampled here is frame bit 9.
    - MOSI=0: go to WRITE.
    - MOSI=1 and `rd_addr_seen`=0: go to READ_ADD.
    - MOSI=1 and `rd_addr_seen`=1: go to READ_DATA.
  - WRITE, READ_ADD, READ_DATA: shift in the remaining 9 bits, then handle frame end as described below.
- Frame end (10th bit sampled):
  - `rx_data` is loaded with the full frame and `rx_valid` is set for exactly one cycle.
  - Any further MOSI bits in the same frame are ignored; no second `rx_valid` is issued.
- `rd_addr_seen` flag:
  - Set on the `rx_valid` of a READ_ADD frame.
  - Cleared on the `rx_valid` of a READ_DATA frame.
  - Unchanged on WRITE frames.
- `rx_data` is passed through unchanged; the RAM decodes bits [9:8] (00 write address, 01 write data, 10 read address, 11 read data).
- READ_DATA response:
  - After its `rx_valid`, the block waits for `tx_valid`=1.
  - On that edge it captures `tx_data` and drives `MISO`=`tx_data[7]`.
  - On the next 7 edges it drives bits 6..0.
  - It then holds `MISO`=0 until `SS_n` goes high.
- `tx_valid` outside the wait window, or a second `tx_valid` during shift-out, is ignored.
- `SS_n`=1 in any non-IDLE state:
  - Next edge goes to IDLE.
  - Any partial frame is discarded with no `rx_valid`.
  - Bit counter and TX shifter are cleared; `MISO`=0.
  - `rd_addr_seen` is retained.
- Asynchronous reset mid-frame forces all reset values immediately.

## Timing
- Edge k: IDLE samples `SS_n`=0 and moves to CHK_CMD. No data bit is captured on this edge.
- Edge k+1: bit 9 is captured.
- Edges k+2 to k+10: bits 8..0 are captured.
- `rx_valid` is high from edge k+10 to edge k+11.
- Read latency:
  - If `tx_valid` arrives at edge m, `MISO` carries bit 7 during cycle m..m+1 and bit 0 during cycle m+7..m+8.
  - The RAM's one-cycle read gives m = k+11.
- Back-to-back frames: `SS_n` must return high for at least 1 edge (return to IDLE) between frames.

## Structure
- Shared package `spi_pkg`:
  - State encoding: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
  - Command constants: `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - Frame-length constant: 10.
- One sub-module, `spi_tx_serializer`:
  - 8-bit load-and-shift register with a 3-bit counter.
  - Inputs: load, data. Outputs: `MISO`, busy.
- The FSM, RX shift register, bit counter and `rd_addr_seen` flag stay in `spi_slave`.

## Test plan
- Reset during idle, then release:
  - Required: all outputs at reset values.
  - Stimulus: `SS_n`=1 for 5 cycles. Required: no `rx_valid`.
- Write address:
  - Stimulus: `SS_n` low, MOSI 0,0,1,1,1,0,0,1,1,0.
  - Required: `rx_data`=10'h0E6 with `rx_valid` for one cycle at edge k+10; state WRITE; `rd_addr_seen` stays 0.
- Write data:
  - Stimulus: frame 10'h1E6.
  - Required: `rx_data`=10'h1E6 with one `rx_valid` pulse; bits 11–12 sent with `SS_n` still low are ignored.
- Read sequence:
  - Stimulus: frame 10'h2E6, then frame 10'h3E6; drive `tx_valid`=1, `tx_data`=8'hA5 at k+11.
  - Required:
    - First frame goes to READ_ADD and sets `rd_addr_seen`.
    - Second frame goes to READ_DATA.
    - `MISO` sequence is 1,0,1,0,0,1,0,1, then 0.
    - `rd_addr_seen` ends at 0.
- Abort:
  - Stimulus: raise `SS_n` after 6 bits of a frame.
  - Required: no `rx_valid`; IDLE next edge; a following full frame 10'h0A5 is received correctly.
- Reset mid-frame:
  - Stimulus: `rst_n`=0 during READ_DATA shift-out.
  - Required: `MISO`=0 and state IDLE immediately, with no clock edge needed; `rd_addr_seen` cleared.
